// File: rtl/rx_cmd_parser.sv
// Line-oriented command parser: turns "<letter> [hex digits] CR|LF" into cmd/arg with a handshake.
// Optional byte echo to the transmitter is built when RX_CMD_ECHO_EN is defined.
module rx_cmd_parser (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  d_rx,
    input  logic        vld_rx,
    output logic        rdy_rx,
    output logic [2:0]  cmd,
    output logic [31:0] arg,
    output logic        has_arg,
    output logic        cmd_vld,
    input  logic        cmd_rdy,
    output logic        err,
    output logic [7:0]  d_tx,
    output logic        vld_tx,
    input  logic        rdy_tx
);
    // state | meaning
    // IDLE  | waiting for a command letter; blanks and line ends ignored
    // ARG   | collecting hex digits until CR/LF
    // HOLD  | command presented on cmd_vld until cmd_rdy
    // ERR   | line rejected; discarding bytes until CR/LF
    typedef enum logic [1:0] {S_IDLE, S_ARG, S_HOLD, S_ERR} state_t;

    state_t      state, state_nxt;
    logic [2:0]  cmd_nxt;
    logic [31:0] arg_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic        has_arg_nxt;
    logic        err_nxt;
    logic        accept;
    logic        echo_block;
    logic        is_blank;
    logic        is_term;
    logic [2:0]  letter;
    logic        hex_ok;
    logic [3:0]  nibble;

    assign accept   = vld_rx && rdy_rx;
    assign is_term  = (d_rx == 8'h0D) || (d_rx == 8'h0A);
    assign is_blank = (d_rx == 8'h20);
    assign rdy_rx   = (state != S_HOLD) && !echo_block;
    assign cmd_vld  = (state == S_HOLD);

    // Letters differ from their lower case only in bit 5, so fold case first.
    always_comb begin
        letter = 3'd0;
        case (d_rx | 8'h20)
            8'h70:   letter = 3'd1;
            8'h72:   letter = 3'd2;
            8'h73:   letter = 3'd3;
            8'h62:   letter = 3'd4;
            8'h67:   letter = 3'd5;
            8'h64:   letter = 3'd6;
            8'h69:   letter = 3'd7;
            default: letter = 3'd0;
        endcase
    end

    always_comb begin
        hex_ok = 1'b0;
        nibble = 4'd0;
        if (d_rx >= 8'h30 && d_rx <= 8'h39) begin
            hex_ok = 1'b1;
            nibble = d_rx[3:0];
        end else if ((d_rx >= 8'h41 && d_rx <= 8'h46) || (d_rx >= 8'h61 && d_rx <= 8'h66)) begin
            hex_ok = 1'b1;
            nibble = d_rx[3:0] + 4'd9;
        end
    end

    always_comb begin
        state_nxt   = state;
        cmd_nxt     = cmd;
        arg_nxt     = arg;
        cnt_nxt     = cnt;
        has_arg_nxt = has_arg;
        err_nxt     = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept && !is_blank && !is_term) begin
                    if (letter != 3'd0) begin
                        cmd_nxt   = letter;
                        arg_nxt   = 32'd0;
                        cnt_nxt   = 4'd0;
                        state_nxt = S_ARG;
                    end else begin
                        state_nxt = S_ERR;
                    end
                end
            end
            S_ARG: begin
                if (accept && !is_blank) begin
                    if (hex_ok) begin
                        if (cnt == 4'd8) begin
                            state_nxt = S_ERR;
                        end else begin
                            arg_nxt = {arg[27:0], nibble};
                            cnt_nxt = cnt + 4'd1;
                        end
                    end else if (is_term) begin
                        has_arg_nxt = (cnt != 4'd0);
                        state_nxt   = S_HOLD;
                    end else begin
                        state_nxt = S_ERR;
                    end
                end
            end
            S_HOLD: begin
                if (cmd_rdy) state_nxt = S_IDLE;
            end
            S_ERR: begin
                if (accept && is_term) begin
                    err_nxt   = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            cmd     <= 3'd0;
            arg     <= 32'd0;
            cnt     <= 4'd0;
            has_arg <= 1'b0;
            err     <= 1'b0;
        end else begin
            state   <= state_nxt;
            cmd     <= cmd_nxt;
            arg     <= arg_nxt;
            cnt     <= cnt_nxt;
            has_arg <= has_arg_nxt;
            err     <= err_nxt;
        end
    end

`ifdef RX_CMD_ECHO_EN
    // One-entry echo buffer; a new byte may land on the same edge the old one drains.
    assign echo_block = vld_tx && !rdy_tx;

    always_ff @(posedge clk) begin
        if (rst) begin
            d_tx   <= 8'd0;
            vld_tx <= 1'b0;
        end else if (accept) begin
            d_tx   <= d_rx;
            vld_tx <= 1'b1;
        end else if (rdy_tx) begin
            vld_tx <= 1'b0;
        end
    end
`else
    logic unused_rdy_tx;
    assign unused_rdy_tx = rdy_tx;
    assign echo_block    = 1'b0;
    assign d_tx          = 8'd0;
    assign vld_tx        = 1'b0;
`endif

endmodule

// File: tb/tb_rx_cmd_parser.sv
// Scoreboard bench for rx_cmd_parser: directed lines, then random lines checked against a line-level model.
module tb_rx_cmd_parser;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  d_rx = 8'd0;
    logic        vld_rx = 1'b0;
    logic        rdy_rx;
    logic [2:0]  cmd;
    logic [31:0] arg;
    logic        has_arg;
    logic        cmd_vld;
    logic        cmd_rdy = 1'b0;
    logic        err;
    logic [7:0]  d_tx;
    logic        vld_tx;
    logic        rdy_tx = 1'b1;

    rx_cmd_parser dut (
        .clk(clk), .rst(rst), .d_rx(d_rx), .vld_rx(vld_rx), .rdy_rx(rdy_rx),
        .cmd(cmd), .arg(arg), .has_arg(has_arg), .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy),
        .err(err), .d_tx(d_tx), .vld_tx(vld_tx), .rdy_tx(rdy_tx)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_err;
        logic [2:0]  cmd;
        logic [31:0] arg;
        bit          has_arg;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] line_q[$];
    logic [7:0] echo_q[$];
    int         vectors = 0;
    int         miscompares = 0;
    bit         cons_auto = 1'b0;
    bit         rtx_auto = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, expv, $time);
        end
    endtask

    function automatic int letter_code(input logic [7:0] c);
        string l = "PRSBGDI";
        for (int i = 0; i < 7; i++)
            if (c == l[i] || c == (l[i] | 8'h20)) return i + 1;
        return 0;
    endfunction

    function automatic int hex_val(input logic [7:0] c);
        if (c >= "0" && c <= "9") return int'(c) - 48;
        if (c >= "A" && c <= "F") return int'(c) - 55;
        if (c >= "a" && c <= "f") return int'(c) - 87;
        return -1;
    endfunction

    // A whole line, blanks removed, is either empty, a letter plus up to 8 hex digits, or rejected.
    task automatic model_line();
        logic [7:0]  s[$];
        exp_t        e;
        bit          bad;
        logic [31:0] val;
        int          h;
        foreach (line_q[i]) if (line_q[i] != 8'h20) s.push_back(line_q[i]);
        line_q.delete();
        if (s.size() == 0) return;
        bad = (letter_code(s[0]) == 0) || (s.size() > 9);
        val = 32'd0;
        for (int i = 1; i < s.size(); i++) begin
            h = hex_val(s[i]);
            if (h < 0) bad = 1'b1;
            else val = val * 16 + 32'(h);
        end
        e.is_err  = bad;
        e.cmd     = bad ? 3'd0 : 3'(letter_code(s[0]));
        e.arg     = bad ? 32'd0 : val;
        e.has_arg = !bad && (s.size() > 1);
        exp_q.push_back(e);
    endtask

    task automatic model_accept(input logic [7:0] b);
`ifdef RX_CMD_ECHO_EN
        echo_q.push_back(b);
`endif
        if (b == 8'h0D || b == 8'h0A) model_line();
        else line_q.push_back(b);
    endtask

    // Called at a negedge; returns at the negedge after the byte was taken.
    task automatic send_byte(input logic [7:0] b);
        logic acc = 1'b0;
        d_rx   = b;
        vld_rx = 1'b1;
        for (int k = 0; k < 300 && !acc; k++) begin
            #1 acc = rdy_rx;
            @(posedge clk);
            if (acc) model_accept(b);
            @(negedge clk);
        end
        vld_rx = 1'b0;
        d_rx   = 8'($urandom);
        if (!acc) chk("byte_accept_timeout", 32'(acc), 32'd1);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst    = 1'b1;
        vld_rx = 1'b0;
        repeat (n) @(negedge clk);
        #1;
        chk("rst_cmd", 32'(cmd), 32'd0);
        chk("rst_arg", arg, 32'd0);
        chk("rst_has_arg", 32'(has_arg), 32'd0);
        chk("rst_cmd_vld", 32'(cmd_vld), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_d_tx", 32'(d_tx), 32'd0);
        chk("rst_vld_tx", 32'(vld_tx), 32'd0);
        exp_q.delete();
        line_q.delete();
        echo_q.delete();
        rst = 1'b0;
        @(negedge clk);
        #1 chk("rdy_rx_after_rst", 32'(rdy_rx), 32'd1);
        @(negedge clk);
    endtask

    task automatic release_cmd();
        cmd_rdy = 1'b1;
        @(negedge clk);
        cmd_rdy = 1'b0;
        #1;
        chk("cmd_vld_drop", 32'(cmd_vld), 32'd0);
        chk("rdy_rx_after_take", 32'(rdy_rx), 32'd1);
        @(negedge clk);
    endtask

    task automatic expect_cmd(input string name, input logic [2:0] c, input logic [31:0] a, input logic h);
        #1;
        chk({name, "_vld"}, 32'(cmd_vld), 32'd1);
        chk({name, "_cmd"}, 32'(cmd), 32'(c));
        chk({name, "_arg"}, arg, a);
        chk({name, "_has_arg"}, 32'(has_arg), 32'(h));
    endtask

    initial forever begin
        @(negedge clk);
        if (cons_auto) cmd_rdy = ($urandom_range(0, 2) == 0);
        if (rtx_auto)  rdy_tx  = ($urandom_range(0, 1) == 0);
    end

    // Monitor: samples mid-low-phase, pops the scoreboard whenever a response appears.
    exp_t cur_exp;
    bit   prev_vld = 1'b0, prev_hs = 1'b0, prev_err = 1'b0;
    initial forever begin
        @(negedge clk);
        #2;
        if (rst) begin
            prev_vld = 1'b0; prev_hs = 1'b0; prev_err = 1'b0;
        end else begin
            if (cmd_vld && err) chk("vld_err_overlap", 32'd1, 32'd0);
            if (prev_hs) chk("vld_after_take", 32'(cmd_vld), 32'd0);
            if (cmd_vld && !prev_vld) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_cmd", 32'(cmd_vld), 32'd0);
                    cur_exp = '{is_err: 1'b1, cmd: 3'd0, arg: 32'd0, has_arg: 1'b0};
                end else begin
                    cur_exp = exp_q.pop_front();
                    chk("resp_is_cmd", 32'(cmd_vld), 32'(!cur_exp.is_err));
                end
                chk("hold_rdy_rx", 32'(rdy_rx), 32'd0);
            end
            if (cmd_vld && !cur_exp.is_err) begin
                chk("sb_cmd", 32'(cmd), 32'(cur_exp.cmd));
                chk("sb_arg", arg, cur_exp.arg);
                chk("sb_has_arg", 32'(has_arg), 32'(cur_exp.has_arg));
            end
            if (err) begin
                chk("err_width", 32'(prev_err), 32'd0);
                if (exp_q.size() == 0) chk("unexpected_err", 32'(err), 32'd0);
                else chk("resp_is_err", 32'(err), 32'(exp_q.pop_front().is_err));
            end
`ifdef RX_CMD_ECHO_EN
            if (vld_tx && rdy_tx) begin
                if (echo_q.size() == 0) chk("unexpected_echo", 32'(vld_tx), 32'd0);
                else chk("echo_byte", 32'(d_tx), 32'(echo_q.pop_front()));
            end
`else
            if (vld_tx || d_tx != 8'd0) chk("echo_tied_off", {23'd0, vld_tx, d_tx}, 32'd0);
`endif
            prev_vld = cmd_vld;
            prev_hs  = cmd_vld && cmd_rdy;
            prev_err = err;
        end
    end

    function automatic logic [7:0] rnd_bad_byte(input bit allow_hex);
        logic [7:0] b;
        do b = 8'($urandom);
        while (b == 8'h20 || b == 8'h0D || b == 8'h0A || letter_code(b) != 0 ||
               (!allow_hex && hex_val(b) >= 0) || (allow_hex && hex_val(b) >= 0 && 0));
        return b;
    endfunction

    task automatic rnd_line();
        logic [7:0] q[$];
        string      letters = "PRSBGDIprsbgdi";
        string      hexs = "0123456789abcdefABCDEF";
        int         kind = $urandom_range(0, 7);
        int         nd;
        if ($urandom_range(0, 3) == 0) q.push_back(8'h20);
        case (kind)
            0, 1, 2, 3, 4: begin
                q.push_back(letters[$urandom_range(0, 13)]);
                nd = (kind == 4) ? $urandom_range(9, 11) : $urandom_range(0, 8);
                for (int i = 0; i < nd; i++) begin
                    if ($urandom_range(0, 4) == 0) q.push_back(8'h20);
                    q.push_back(hexs[$urandom_range(0, 21)]);
                end
            end
            5: begin
                q.push_back(rnd_bad_byte(1'b1));
                q.push_back(hexs[$urandom_range(0, 21)]);
            end
            6: begin
                q.push_back(letters[$urandom_range(0, 13)]);
                q.push_back(hexs[$urandom_range(0, 21)]);
                q.push_back(rnd_bad_byte(1'b0));
                q.push_back(hexs[$urandom_range(0, 21)]);
            end
            default: if ($urandom_range(0, 1) == 0) q.push_back(8'h20);
        endcase
        q.push_back($urandom_range(0, 1) ? 8'h0D : 8'h0A);
        if ($urandom_range(0, 3) == 0) q.push_back(8'h0A);
        foreach (q[i]) begin
            send_byte(q[i]);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    initial begin
        int guard;
        do_reset(2);

        // "B 1a2F\r" held 20 cycles before being taken
        send_str("B 1a2F");
        send_byte(8'h0D);
        expect_cmd("b_line", 3'd4, 32'h0000_1A2F, 1'b1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1 chk("b_line_held", {cmd_vld, 28'd0, cmd}, {1'b1, 28'd0, 3'd4});
        end
        @(negedge clk);
        release_cmd();

        send_str("s");
        send_byte(8'h0A);
        expect_cmd("s_line", 3'd3, 32'd0, 1'b0);
        release_cmd();
        send_byte(8'h0D);
        send_byte(8'h0D);
        repeat (4) @(negedge clk);

        send_str("G 123456789");
        send_byte(8'h0D);
        #1 chk("g9_err", {30'd0, err, cmd_vld}, 32'd2);
        @(negedge clk);
        #1 chk("g9_err_once", 32'(err), 32'd0);
        @(negedge clk);

        send_str("X5");
        send_byte(8'h0D);
        #1 chk("x5_err", 32'(err), 32'd1);
        @(negedge clk);
        send_str("p");
        send_byte(8'h0D);
        expect_cmd("p_line", 3'd1, 32'd0, 1'b0);
        release_cmd();

        send_str("D4");
        do_reset(1);
        send_str("R");
        send_byte(8'h0D);
        expect_cmd("r_after_rst", 3'd2, 32'd0, 1'b0);
        release_cmd();

`ifdef RX_CMD_ECHO_EN
        rdy_tx = 1'b0;
        send_byte(8'h49);
        #1;
        chk("echo_vld", 32'(vld_tx), 32'd1);
        chk("echo_d", 32'(d_tx), 32'h49);
        chk("echo_stall_rdy", 32'(rdy_rx), 32'd0);
        rdy_tx = 1'b1;
        @(negedge clk);
        rdy_tx = 1'b0;
        #1;
        chk("echo_drained", 32'(vld_tx), 32'd0);
        chk("echo_rdy_back", 32'(rdy_rx), 32'd1);
        rdy_tx = 1'b1;
        @(negedge clk);
        send_byte(8'h0D);
        expect_cmd("i_line", 3'd7, 32'd0, 1'b0);
        release_cmd();
`endif

        cons_auto = 1'b1;
        rtx_auto  = 1'b1;
        for (int n = 0; n < 150; n++) rnd_line();

        guard = 0;
        while ((exp_q.size() != 0 || cmd_vld) && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        cons_auto = 1'b0;
        cmd_rdy   = 1'b0;
        rtx_auto  = 1'b0;
        rdy_tx    = 1'b1;
        repeat (5) @(negedge clk);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        chk("echo_drained_all", 32'(echo_q.size()), 32'd0);
        chk("line_buffer_empty", 32'(line_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/rx_cmd_parser.md
RX_CMD_PARSER -- requirements
Module: rx_cmd_parser

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock, 9600*16 Hz domain shared with uart_rx.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port d_rx, input, 8 bits: received byte from uart_rx.
REQ-004 SHALL have port vld_rx, input, 1 bit: d_rx holds a byte waiting to be taken.
REQ-005 SHALL have port rdy_rx, output, 1 bit: parser can accept a byte this cycle.
REQ-006 SHALL have port cmd, output, 3 bits: decoded command code.
REQ-007 SHALL have port arg, output, 32 bits: hex operand.
REQ-008 SHALL have port has_arg, output, 1 bit: at least one hex digit was given.
REQ-009 SHALL have port cmd_vld, output, 1 bit: cmd, arg and has_arg are valid.
REQ-010 SHALL have port cmd_rdy, input, 1 bit: the consumer takes the command.
REQ-011 SHALL have port err, output, 1 bit: one-cycle pulse for a rejected line.
REQ-012 SHALL have ports d_tx (output, 8 bits), vld_tx (output, 1 bit) and rdy_tx (input, 1 bit): echo path to the transmitter.

Function
REQ-013 SHALL accept a byte only on a cycle where vld_rx=1 and rdy_rx=1, and SHALL act on that byte at the same clock edge.
REQ-014 SHALL implement the states IDLE, ARG, HOLD and ERR.
REQ-015 IDLE SHALL ignore space (0x20), CR (0x0D) and LF (0x0A).
REQ-016 IDLE SHALL map a command letter, either case, to cmd as follows: P=1, R=2, S=3, B=4, G=5, D=6, I=7. On such a letter it SHALL clear arg, clear the digit count and go to ARG.
REQ-017 IDLE SHALL go to ERR on any other byte.
REQ-018 ARG SHALL ignore space.
REQ-019 ARG SHALL shift a hex digit (0-9, A-F, a-f) in as arg={arg[27:0],nibble} and increment a 4-bit digit count.
REQ-020 In ARG, a 9th hex digit SHALL go to ERR.
REQ-021 In ARG, CR or LF SHALL go to HOLD and set has_arg to (digit count != 0).
REQ-022 In ARG, any other byte SHALL go to ERR.
REQ-023 HOLD SHALL drive cmd_vld=1 starting the cycle after the terminator edge, with rdy_rx=0 and cmd, arg and has_arg held stable.
REQ-024 On the HOLD cycle where cmd_rdy=1, the parser SHALL drop cmd_vld at the next edge and go to IDLE; there SHALL be no combinational path from cmd_rdy to rdy_rx.
REQ-025 ERR SHALL discard bytes until CR or LF is accepted, then pulse err=1 for exactly one cycle and go to IDLE.
REQ-026 cmd_vld and err SHALL never be high together.
REQ-027 rdy_rx SHALL be 1 in IDLE, ARG and ERR, and 0 in HOLD, subject to REQ-033.
REQ-028 A line of only CR/LF SHALL produce neither cmd_vld nor err.

Reset
REQ-029 While rst=1 at an edge, the parser SHALL go to IDLE, with cmd=0, arg=0, has_arg=0, cmd_vld=0, err=0, d_tx=0, vld_tx=0 and the digit count at 0.
REQ-030 rdy_rx SHALL be 1 on the first cycle after rst falls.
REQ-031 rst asserted mid-line or in HOLD SHALL abandon the partial or pending command with no err pulse.

Configuration
REQ-032 The macro RX_CMD_ECHO_EN SHALL select whether echo is built in.
REQ-033 With RX_CMD_ECHO_EN defined:
- every accepted byte SHALL be loaded into a one-entry echo register: d_tx=byte and vld_tx=1 from the next cycle until a cycle with rdy_tx=1;
- rdy_rx SHALL be 0 while vld_tx=1 and rdy_tx=0;
- a byte accepted on the same cycle the echo entry drains SHALL reload the entry.
REQ-034 Without RX_CMD_ECHO_EN, d_tx SHALL be tied to 0 and vld_tx to 0, rdy_tx SHALL be ignored, and rdy_rx SHALL depend only on state.

Verification
REQ-035 Bytes "B 1a2F\r" with cmd_rdy=0 SHALL give cmd_vld=1, cmd=4, arg=0x00001A2F and has_arg=1, held for 20 cycles; cmd_rdy=1 SHALL then give cmd_vld=0 on the next cycle and rdy_rx=1.
REQ-036 Bytes "s\n" SHALL give cmd=3, arg=0 and has_arg=0; a following bytes "\r\r" SHALL give no cmd_vld and no err.
REQ-037 Bytes "G 123456789\r" SHALL give one err pulse after the '\r' is accepted, with no cmd_vld.
REQ-038 Bytes "X5\r" SHALL give one err pulse; a following "p\r" SHALL give cmd=1.
REQ-039 Sending 'D' and '4', then rst=1 for 1 cycle, then "R\r" SHALL give cmd=2 and arg=0 with no err.
REQ-040 With RX_CMD_ECHO_EN defined and rdy_tx=0, sending 'I' SHALL give vld_tx=1 and d_tx=0x49 with rdy_rx=0; then rdy_tx=1 for 1 cycle SHALL give vld_tx=0 and rdy_rx=1.
